// File: rtl/calc_pkg.sv
// Shared calculator control-path definitions: key codes, scanner states and the
// keypad row/column to key-code map.
package calc_pkg;

   localparam logic [3:0] KEY_0    = 4'h0;
   localparam logic [3:0] KEY_1    = 4'h1;
   localparam logic [3:0] KEY_2    = 4'h2;
   localparam logic [3:0] KEY_3    = 4'h3;
   localparam logic [3:0] KEY_4    = 4'h4;
   localparam logic [3:0] KEY_5    = 4'h5;
   localparam logic [3:0] KEY_6    = 4'h6;
   localparam logic [3:0] KEY_7    = 4'h7;
   localparam logic [3:0] KEY_8    = 4'h8;
   localparam logic [3:0] KEY_9    = 4'h9;
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_HASH = 4'hE;
   localparam logic [3:0] KEY_STAR = 4'hF;

   typedef enum logic [2:0] {
      StScan,
      StDebounce,
      StPress,
      StWaitRel
   } scan_state_e;

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      unique case ({row, col})
         4'b00_00: code = KEY_1;
         4'b00_01: code = KEY_2;
         4'b00_10: code = KEY_3;
         4'b00_11: code = KEY_A;
         4'b01_00: code = KEY_4;
         4'b01_01: code = KEY_5;
         4'b01_10: code = KEY_6;
         4'b01_11: code = KEY_B;
         4'b10_00: code = KEY_7;
         4'b10_01: code = KEY_8;
         4'b10_10: code = KEY_9;
         4'b10_11: code = KEY_C;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = KEY_0;
         4'b11_10: code = KEY_HASH;
         default:  code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
module key_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] async_i,
   output logic [3:0] sync_o
);

   logic [3:0] ff1_q, ff2_q;

   // Rows idle high (pulled up), so reset to the released level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ff1_q <= 4'hF;
         ff2_q <= 4'hF;
      end else begin
         ff1_q <= async_i;
         ff2_q <= ff1_q;
      end
   end

   assign sync_o = ff2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column walk, row debounce and one strobe per press.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV     = 4096,
   parameter int unsigned DEBOUNCE_CYC = 65536
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] rows_n,
   output logic [3:0] cols_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);
   import calc_pkg::*;

   localparam int unsigned DivW = $clog2(SCAN_DIV);
   localparam int unsigned DebW = $clog2(DEBOUNCE_CYC);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYC - 1);

   scan_state_e     state_q, state_d;
   logic [1:0]      col_q, col_d;
   logic [1:0]      row_q, row_d;
   logic [DivW-1:0] div_q, div_d;
   logic [DebW-1:0] deb_q, deb_d;
   logic [3:0]      code_q, code_d;

   logic [3:0] rows_s;
   logic [1:0] low_row;
   logic       any_low;
   logic       row_low;

   key_sync u_key_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (rows_n),
      .sync_o  (rows_s)
   );

   // Descending walk so the lowest-index low row wins.
   always_comb begin
      low_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows_s[i]) low_row = 2'(i);
      end
   end

   assign any_low = ~&rows_s;
   assign row_low = ~rows_s[row_q];

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      div_d   = div_q;
      deb_d   = deb_q;
      code_d  = code_q;
      unique case (state_q)
         StScan: begin
            if (div_q == DivLast) begin
               div_d = '0;
               if (any_low) begin
                  row_d   = low_row;
                  deb_d   = '0;
                  state_d = StDebounce;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StDebounce: begin
            if (!row_low) begin
               state_d = StScan;
               div_d   = '0;
               deb_d   = '0;
            end else if (deb_q == DebLast) begin
               state_d = StPress;
               code_d  = key_map(row_q, col_q);
               deb_d   = '0;
            end else begin
               deb_d = deb_q + DebW'(1);
            end
         end
         StPress: begin
            state_d = StWaitRel;
            deb_d   = '0;
         end
         StWaitRel: begin
            if (row_low) begin
               deb_d = '0;
            end else if (deb_q == DebLast) begin
               state_d = StScan;
               col_d   = col_q + 2'd1;
               div_d   = '0;
               deb_d   = '0;
            end else begin
               deb_d = deb_q + DebW'(1);
            end
         end
         default: begin
            state_d = StScan;
            div_d   = '0;
            deb_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StScan;
         col_q   <= 2'd0;
         row_q   <= 2'd0;
         div_q   <= '0;
         deb_q   <= '0;
         code_q  <= 4'h0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         div_q   <= div_d;
         deb_q   <= deb_d;
         code_q  <= code_d;
      end
   end

   assign cols_n    = ~(4'b0001 << col_q);
   assign key_code  = code_q;
   assign key_valid = (state_q == StPress);
   assign key_held  = (state_q == StWaitRel);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows, a monitor checks strobes.
module tb_keypad_scanner;

   logic       clk;
   logic       rst_n;
   logic [3:0] rows_n;
   logic [3:0] cols_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [3:0][3:0] pressed;  // [row][col]
   logic [3:0]      exp_q[$];
   int              n_checks = 0;
   int              n_pass = 0;
   int              pulse_cnt = 0;
   int              cyc = 0;
   int              last_pulse_cyc = 0;
   int              base = 0;
   int              snap;

   keypad_scanner #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CYC (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rows_n    (rows_n),
      .cols_n    (cols_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         rows_n[r] = 1'b1;
         for (int c = 0; c < 4; c++) begin
            if (pressed[r][c] && !cols_n[c]) rows_n[r] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
   endtask

   // Monitor: every strobe must match the head of the expected-code queue.
   initial begin
      logic prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_valid && rst_n) check("held_after_pulse", 32'(key_held), 32'd1);
         if (rst_n && key_valid) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
            check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
         end
         prev_valid = rst_n && key_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick(1);
         check("rst_cols_n", 32'(cols_n), 32'hE);
         check("rst_valid", 32'(key_valid), 32'd0);
         check("rst_held", 32'(key_held), 32'd0);
         check("rst_code", 32'(key_code), 32'h0);
      end
      rst_n = 1'b1;
      base = cyc;
   endtask

   task automatic wait_pulses(input string name, input int target, input int budget);
      for (int i = 0; i < budget && pulse_cnt < target; i++) tick(1);
      check(name, 32'(pulse_cnt), 32'(target));
   endtask

   task automatic wait_release(input string name, input int budget);
      for (int i = 0; i < budget && key_held; i++) tick(1);
      check(name, 32'(key_held), 32'd0);
   endtask

   initial begin
      logic [3:0] walk_exp [5];
      walk_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      rst_n   = 1'b0;
      pressed = '0;

      // Reset with '5' held; scanning restarts at c0, '5' found at c1 sample cycle 7.
      pressed[1][1] = 1'b1;
      exp_q.push_back(4'h5);
      do_reset(3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_cols", 32'(cols_n), 32'(i < 4 ? 4'b1110 : 4'b1101));
      end
      wait_pulses("pulse_5", 1, 60);
      check("latency_5", 32'(last_pulse_cyc - base), 32'd16);
      pressed[1][1] = 1'b0;
      wait_release("release_5", 40);

      // Clean '#' press for 40 cycles; release debounce lasts 8 stable-high cycles.
      exp_q.push_back(4'hE);
      pressed[3][2] = 1'b1;
      tick(40);
      check("pulse_hash", 32'(pulse_cnt), 32'd2);
      check("held_hash", 32'(key_held), 32'd1);
      pressed[3][2] = 1'b0;
      tick(9);
      check("held_until_debounced", 32'(key_held), 32'd1);
      tick(1);
      check("released_hash", 32'(key_held), 32'd0);
      check("next_col_hash", 32'(cols_n), 32'h7);
      check("drained_hash", 32'(exp_q.size()), 32'd0);

      // Bounce on '7': toggles every 3 cycles, stable from cycle 30, detect at 33.
      do_reset(2);
      exp_q.push_back(4'h7);
      for (int k = 0; k < 10; k++) begin
         pressed[2][0] = (k % 2 == 0);
         tick(3);
      end
      pressed[2][0] = 1'b1;
      wait_pulses("pulse_7", 3, 60);
      check("latency_7", 32'(last_pulse_cyc - base), 32'd42);
      pressed[2][0] = 1'b0;
      wait_release("release_7", 40);

      // Idle column walk, then '1' (c0) and 'D' (c3).
      do_reset(1);
      for (int i = 0; i < 5; i++) begin
         if (i == 0) @(negedge clk);
         else repeat (4) @(negedge clk);
         check("col_walk", 32'(cols_n), 32'(walk_exp[i]));
      end
      exp_q.push_back(4'h1);
      pressed[0][0] = 1'b1;
      wait_pulses("pulse_1", 4, 60);
      pressed[0][0] = 1'b0;
      wait_release("release_1", 40);
      exp_q.push_back(4'hD);
      pressed[3][3] = 1'b1;
      wait_pulses("pulse_d", 5, 60);
      pressed[3][3] = 1'b0;
      wait_release("release_d", 40);

      // '2' and '0' in c1: lowest row wins; '9' ignored while '2' is held.
      exp_q.push_back(4'h2);
      pressed[0][1] = 1'b1;
      pressed[3][1] = 1'b1;
      wait_pulses("pulse_2", 6, 60);
      pressed[2][2] = 1'b1;
      tick(30);
      check("no_pulse_while_held", 32'(pulse_cnt), 32'd6);
      exp_q.push_back(4'h9);
      pressed[0][1] = 1'b0;
      pressed[3][1] = 1'b0;
      wait_pulses("pulse_9", 7, 60);
      pressed[2][2] = 1'b0;
      wait_release("release_9", 40);

      // Reset during DEBOUNCE (cycle 6) and again during WAIT_REL.
      do_reset(1);
      pressed[0][0] = 1'b1;
      tick(6);
      do_reset(1);
      exp_q.push_back(4'h1);
      wait_pulses("pulse_1_again", 8, 60);
      check("latency_1", 32'(last_pulse_cyc - base), 32'd12);
      check("held_before_rst", 32'(key_held), 32'd1);
      do_reset(1);
      pressed[0][0] = 1'b0;
      snap = pulse_cnt;
      tick(40);
      check("no_pulse_after_rst", 32'(pulse_cnt), 32'(snap));
      check("drained_final", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the calculator control path.
- Scans a 4x4 matrix keypad, synchronises and debounces the row inputs, and encodes the pressed key into a 4-bit code.
- Emits exactly one single-cycle strobe per physical press. The key code plus strobe feed the control decoder's key field and valid bit; the decoder concatenates them with the calculator state bits.

Parameters:
- SCAN_DIV, 4096: clock cycles each column is driven before the rows are sampled (settle time). Must be ≥2.
- DEBOUNCE_CYC, 65536: consecutive stable cycles required to accept a press or a release. Must be ≥2.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- rows_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- cols_n  output  4  column drive, one-hot active-low
- key_code  output  4  encoded key: digits 0x0-0x9, A=0xA, B=0xB, C=0xC, D=0xD, #=0xE, *=0xF
- key_valid  output  1  one-cycle strobe; key_code is valid in the same cycle
- key_held  output  1  high while the accepted key is still pressed (release not yet debounced)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=SCAN, column index=0, cols_n=4'b1110, key_code=4'h0, key_valid=0, key_held=0, all counters=0.
- Reset sampled low mid-operation returns to these values on the next edge. No strobe is generated.
- Synchroniser: rows_n passes through 2 flops to give rows_s. All decisions use rows_s only.
- Keypad map, rows r0..r3 by columns c0..c3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- cols_n: always exactly one zero, at bit = column index. It never changes outside SCAN.
- SCAN:
  - The divider counts 0..SCAN_DIV-1 while driving the current column.
  - At count SCAN_DIV-1: if any rows_s bit is 0, latch row = lowest-index low row, latch the column, clear the debounce counter, and go to DEBOUNCE.
  - Otherwise advance the column (3 wraps to 0) and restart the divider.
- DEBOUNCE (column held):
  - Each cycle the latched row is low, the counter increments.
  - When the counter is DEBOUNCE_CYC-1 and the row is still low, go to PRESS.
  - Any high sample goes to SCAN on the same column with the divider cleared. No strobe.
- PRESS (exactly one cycle):
  - key_valid=1.
  - key_code is loaded from the latched row/column on entry and is valid in this cycle.
  - Go to WAIT_REL with the debounce counter cleared.
- WAIT_REL:
  - key_held=1.
  - A high latched row increments the counter. A low sample clears it.
  - When the counter is DEBOUNCE_CYC-1 and the row is high, go to SCAN on the next column with key_held=0.
- Latency: with the detecting SCAN sample at cycle T, key_valid is high at cycle T+1+DEBOUNCE_CYC.
- key_code holds its last value outside PRESS. It changes only on entry to PRESS.
- Multiple keys:
  - Only the latched row/column is tracked.
  - Other keys pressed while in DEBOUNCE or WAIT_REL are ignored.
  - Two rows low in one column: the lowest row wins.
- No auto-repeat. A held key produces exactly one key_valid.
- Counter widths: $clog2 of the respective parameter. No counter wraps, because each resets on every transition.

Decomposition:
- Shared package calc_pkg:
  - key-code localparams KEY_0..KEY_9, KEY_A..KEY_D, KEY_HASH=4'hE, KEY_STAR=4'hF;
  - 3-bit scanner state enum {SCAN, DEBOUNCE, PRESS, WAIT_REL};
  - 16-entry row/column-to-code function.
- One sub-module: key_sync, a 4-bit two-flop synchroniser with synchronous active-low reset.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8, keypad model drives rows_n from held keys and cols_n):
- Reset: hold rst_n=0 for 3 cycles with key '5' pressed -> cols_n=1110, key_valid=0, key_code=0 throughout; after release of reset, scanning resumes from c0.
- Clean press of '#' (r3,c2) for 40 cycles -> exactly one key_valid pulse with key_code=0xE. key_held is high from the cycle after the pulse until 8 stable-high cycles after release.
- Bounce: '7' toggles every 3 cycles for 30 cycles, then is stable low -> no pulse during the bounce; a single pulse with key_code=0x7 exactly 9 cycles after the first SCAN sample of the stable period.
- Column wrap: '1' (c0) and 'D' (c3) pressed sequentially with release between -> codes 0x1 then 0xD, one pulse each; cols_n walks 1110→1101→1011→0111→1110.
- Two keys in one column ('2' r0 and '0' r3 in c1) -> code 0x2 only. A second key pressed during WAIT_REL of '2' produces no pulse until '2' is released.
- Reset asserted in DEBOUNCE and again in WAIT_REL -> next cycle state=SCAN, key_held=0, no key_valid.
